// File: rtl/msrv32_pkg.sv
// Shared definitions for the fetch/flush controller and the decode mux.
package msrv32_pkg;

  localparam logic [1:0] FF_RST_FLUSH = 2'd0;
  localparam logic [1:0] FF_RUN       = 2'd1;
  localparam logic [1:0] FF_WAIT_MEM  = 2'd2;
  localparam logic [1:0] FF_SQUASH    = 2'd3;

  // addi x0, x0, 0 -- injected by the decode mux while flush is high
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/msrv32_bubble_counter.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
module msrv32_bubble_counter #(
  parameter int unsigned CNT_W = 4,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/msrv32_fetch_flush_ctrl.sv
// Fetch pacing / decode flush sequencer. Define MSRV32_FLUSH_PERF_EN to add
// a saturating count of accepted redirects on flush_count_out.
//
// state        | meaning
// FF_RST_FLUSH | post-reset bubbles, no fetch, redirect/stall ignored
// FF_RUN       | normal fetch; word valid when imem ready
// FF_WAIT_MEM  | fetch outstanding, imem not ready
// FF_SQUASH    | bubbles after redirect while fetching the target
module msrv32_fetch_flush_ctrl
  import msrv32_pkg::*;
#(
  parameter int unsigned RST_FLUSH_CYCLES = 2,
  parameter int unsigned FLUSH_DEPTH      = 1,
  parameter int unsigned CNT_W            = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        redirect_in,
  input  logic        ms_riscv32_mp_instr_hready_in,
  input  logic        stall_in,
  output logic        flush_out,
  output logic        instr_req_out,
  output logic        instr_valid_out,
  output logic        pc_load_out
`ifdef MSRV32_FLUSH_PERF_EN
  ,
  output logic [31:0] flush_count_out
`endif
);

  localparam logic [CNT_W-1:0] RST_RELOAD = CNT_W'(RST_FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SQ_RELOAD  = CNT_W'(FLUSH_DEPTH - 1);

  logic [1:0] state, state_nxt;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic       hready;

  assign hready = ms_riscv32_mp_instr_hready_in;

  msrv32_bubble_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (RST_RELOAD)
  ) u_bubble_counter (
    .clk      (ms_riscv32_mp_clk_in),
    .rst_n    (ms_riscv32_mp_rst_in),
    .load     (cnt_load),
    .load_val (SQ_RELOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) state <= FF_RST_FLUSH;
    else                       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    flush_out       = 1'b0;
    instr_req_out   = 1'b0;
    instr_valid_out = 1'b0;
    pc_load_out     = 1'b0;
    case (state)
      FF_RST_FLUSH: begin
        flush_out = 1'b1;
        cnt_dec   = 1'b1;
        if (cnt_zero) state_nxt = FF_RUN;
      end
      FF_RUN: begin
        instr_req_out = 1'b1;
        if (redirect_in) begin
          pc_load_out = 1'b1;
          cnt_load    = 1'b1;
          state_nxt   = FF_SQUASH;
        end else if (!hready) begin
          state_nxt = FF_WAIT_MEM;
        end else begin
          // a stalled back end keeps the current word, so the PC must hold
          instr_valid_out = 1'b1;
          pc_load_out     = !stall_in;
        end
      end
      FF_WAIT_MEM: begin
        instr_req_out = 1'b1;
        if (redirect_in) begin
          pc_load_out = 1'b1;
          cnt_load    = 1'b1;
          state_nxt   = FF_SQUASH;
        end else if (hready) begin
          state_nxt = FF_RUN;
        end
      end
      default: begin
        flush_out     = 1'b1;
        instr_req_out = 1'b1;
        if (redirect_in) begin
          pc_load_out = 1'b1;
          cnt_load    = 1'b1;
        end else if (!cnt_zero) begin
          cnt_dec = 1'b1;
        end else begin
          state_nxt = hready ? FF_RUN : FF_WAIT_MEM;
        end
      end
    endcase
  end

`ifdef MSRV32_FLUSH_PERF_EN
  logic [31:0] flush_count;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      flush_count <= '0;
    end else if (redirect_in && (state != FF_RST_FLUSH) && (flush_count != 32'hFFFF_FFFF)) begin
      flush_count <= flush_count + 32'd1;
    end
  end

  assign flush_count_out = flush_count;
`endif

endmodule

// File: tb/tb_msrv32_fetch_flush_ctrl.sv
// Directed bench for msrv32_fetch_flush_ctrl (default and FLUSH_DEPTH=3 instances).
module tb_msrv32_fetch_flush_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic redirect, redirect3, hready, stall;
  logic flush, req, valid, pcl;
  logic flush3, req3, valid3, pcl3;
  logic [3:0] o, o3;
  int checks = 0;
  int failures = 0;
`ifdef MSRV32_FLUSH_PERF_EN
  logic [31:0] fcnt, fcnt3;
`endif

  always #5 clk = ~clk;

  msrv32_fetch_flush_ctrl dut (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst_n),
    .redirect_in                   (redirect),
    .ms_riscv32_mp_instr_hready_in (hready),
    .stall_in                      (stall),
    .flush_out                     (flush),
    .instr_req_out                 (req),
    .instr_valid_out               (valid),
    .pc_load_out                   (pcl)
`ifdef MSRV32_FLUSH_PERF_EN
    , .flush_count_out             (fcnt)
`endif
  );

  msrv32_fetch_flush_ctrl #(.FLUSH_DEPTH(3)) dut3 (
    .ms_riscv32_mp_clk_in          (clk),
    .ms_riscv32_mp_rst_in          (rst_n),
    .redirect_in                   (redirect3),
    .ms_riscv32_mp_instr_hready_in (hready),
    .stall_in                      (stall),
    .flush_out                     (flush3),
    .instr_req_out                 (req3),
    .instr_valid_out               (valid3),
    .pc_load_out                   (pcl3)
`ifdef MSRV32_FLUSH_PERF_EN
    , .flush_count_out             (fcnt3)
`endif
  );

  // {flush, req, valid, pc_load}
  assign o  = {flush, req, valid, pcl};
  assign o3 = {flush3, req3, valid3, pcl3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // check outputs mid-cycle, then advance to just after the next rising edge
  task automatic step(input string tag, input logic [3:0] e);
    @(negedge clk);
    chk(tag, {28'd0, o}, {28'd0, e});
    @(posedge clk); #1;
  endtask

  task automatic step3(input string tag, input logic [3:0] e);
    @(negedge clk);
    chk(tag, {28'd0, o3}, {28'd0, e});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect3 = 1'b0; hready = 1'b1; stall = 1'b0;
    #1;
    chk("reset_outs", {28'd0, o}, 32'h8);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    step("rst_flush_c1", 4'b1000);
    step("rst_flush_c2", 4'b1000);
    step("run_c3", 4'b0111);
    step("run_c4", 4'b0111);

    redirect = 1'b1;
    step("run_redirect", 4'b0101);
    redirect = 1'b0;
    step("squash_1", 4'b1100);
    step("post_squash", 4'b0111);

    hready = 1'b0;
    step("nordy_1", 4'b0100);
    step("nordy_2", 4'b0100);
    step("nordy_3", 4'b0100);
    hready = 1'b1;
    step("wait_rdy", 4'b0100);
    step("resume", 4'b0111);

    stall = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("stall_%0d", i), 4'b0110);
    stall = 1'b0;
    step("unstall", 4'b0111);

    stall = 1'b1; redirect = 1'b1;
    step("stall_redirect", 4'b0101);
    redirect = 1'b0;
    step("stall_squash", 4'b1100);
    step("stall_run", 4'b0110);
    stall = 1'b0;

    hready = 1'b0;
    step("wm_enter", 4'b0100);
    redirect = 1'b1;
    step("wm_redirect", 4'b0101);
    redirect = 1'b0;
    step("sq_to_wait", 4'b1100);
    hready = 1'b1;
    step("wait_again", 4'b0100);
    step("run_again", 4'b0111);

    redirect3 = 1'b1;
    step3("d3_redirect", 4'b0101);
    redirect3 = 1'b0;
    step3("d3_sq1", 4'b1100);
    redirect3 = 1'b1;
    step3("d3_sq2_redirect", 4'b1101);
    redirect3 = 1'b0;
    step3("d3_reload_1", 4'b1100);
    step3("d3_reload_2", 4'b1100);
    step3("d3_reload_3", 4'b1100);
    step3("d3_run", 4'b0111);

`ifdef MSRV32_FLUSH_PERF_EN
    chk("perf_count", fcnt, 32'd3);
    chk("perf_count_d3", fcnt3, 32'd2);
`endif

    redirect = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    step("pre_reset_squash", 4'b1100);
    // squash lasted one cycle; redirect again so reset lands inside SQUASH
    redirect = 1'b1;
    @(posedge clk); #1;
    redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {28'd0, o}, 32'h8);
`ifdef MSRV32_FLUSH_PERF_EN
    chk("perf_cleared", fcnt, 32'd0);
`endif
    step("held_reset", 4'b1000);
    rst_n = 1'b1;
    redirect = 1'b1;
    step("rst_ignore_redir", 4'b1000);
    redirect = 1'b0;
    step("rst_flush_2b", 4'b1000);
    step("run_after_rst", 4'b0111);
`ifdef MSRV32_FLUSH_PERF_EN
    chk("perf_ignore_rst", fcnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
